// File: rtl/me_search_feeder.sv
// Read-side sequencer for full-search integer motion estimation.
// Loads the current macroblock rows, then streams search-window column strips and
// tags each completed candidate SAD with its (cand_x, cand_y) offset.
module me_search_feeder #(
    parameter int unsigned MACRO_DIM  = 16,
    parameter int unsigned SEARCH_DIM = 48,
    parameter int unsigned PIPE_LAT   = 2
) (
    input  logic                                           i_clk,
    input  logic                                           i_rst_n,
    input  logic                                           i_start,
    output logic                                           o_busy,
    output logic                                           o_done,
    output logic                                           o_cur_rd_en,
    output logic [$clog2(MACRO_DIM)-1:0]                   o_cur_row,
    input  logic [8*MACRO_DIM-1:0]                         i_cur_data,
    output logic                                           o_srch_rd_en,
    output logic [$clog2(SEARCH_DIM)-1:0]                  o_srch_row,
    output logic [$clog2(SEARCH_DIM)-1:0]                  o_srch_col,
    input  logic [8*MACRO_DIM-1:0]                         i_srch_data,
    output logic [8*MACRO_DIM-1:0]                         o_pixel_cpr_out,
    output logic [8*MACRO_DIM-1:0]                         o_pixel_spr_out,
    output logic                                           o_en_cpr,
    output logic                                           o_en_spr,
    output logic                                           o_valid,
    output logic [$clog2(SEARCH_DIM-MACRO_DIM+1)-1:0]      o_cand_x,
    output logic [$clog2(SEARCH_DIM-MACRO_DIM+1)-1:0]      o_cand_y
);

    localparam int unsigned NPOS = SEARCH_DIM - MACRO_DIM + 1;
    localparam int unsigned CW   = $clog2(MACRO_DIM);
    localparam int unsigned SW   = $clog2(SEARCH_DIM);
    localparam int unsigned NW   = $clog2(NPOS);
    localparam int unsigned PW   = 8 * MACRO_DIM;
    localparam int unsigned DW   = $clog2(PIPE_LAT + 1) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StLoadCur,
        StStream,
        StDrain,
        StFin
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [CW-1:0]   r_cur_row;
    logic [SW-1:0]   r_srch_row;
    logic [NW-1:0]   r_srch_col;
    logic [DW-1:0]   r_drain;

    logic            w_cur_last;
    logic            w_row_last;
    logic            w_col_last;
    logic            w_drain_last;
    logic            w_cur_rd_en;
    logic            w_srch_rd_en;

    logic            r_en_cpr;
    logic            r_en_spr;
    logic [PW-1:0]   r_pix_cpr;
    logic [PW-1:0]   r_pix_spr;
    logic [SW-1:0]   r_beat_row;
    logic [NW-1:0]   r_beat_col;

    logic            w_beat_v;
    logic [NW-1:0]   w_beat_x;
    logic [NW-1:0]   w_beat_y;
    logic            w_out_v;
    logic [NW-1:0]   w_out_x;
    logic [NW-1:0]   w_out_y;
    logic [NW-1:0]   r_cand_x;
    logic [NW-1:0]   r_cand_y;

    assign w_cur_last   = (r_cur_row == CW'(MACRO_DIM - 1));
    assign w_row_last   = (r_srch_row == SW'(SEARCH_DIM - 1));
    assign w_col_last   = (r_srch_col == NW'(NPOS - 1));
    assign w_drain_last = (r_drain == DW'(PIPE_LAT));
    assign w_cur_rd_en  = (r_state == StLoadCur);
    assign w_srch_rd_en = (r_state == StStream);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; start is only honoured from idle
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:    if (i_start) w_state_next = StLoadCur;
            StLoadCur: if (w_cur_last) w_state_next = StStream;
            StStream:  if (w_row_last && w_col_last) w_state_next = StDrain;
            StDrain:   if (w_drain_last) w_state_next = StFin;
            StFin:     w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    // Read address counters; each returns to 0 explicitly at the end of its sweep
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cur_row  <= '0;
            r_srch_row <= '0;
            r_srch_col <= '0;
            r_drain    <= '0;
        end else begin
            if (r_state == StLoadCur) begin
                r_cur_row <= w_cur_last ? '0 : r_cur_row + CW'(1);
            end
            if (r_state == StStream) begin
                if (w_row_last) begin
                    r_srch_row <= '0;
                    r_srch_col <= w_col_last ? '0 : r_srch_col + NW'(1);
                end else begin
                    r_srch_row <= r_srch_row + SW'(1);
                end
            end
            if (r_state == StDrain) begin
                r_drain <= w_drain_last ? '0 : r_drain + DW'(1);
            end
        end
    end

    // Return path: memory data is captured at the edge that closes the read cycle,
    // so the enable and the pixel word appear together one cycle after the read.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_en_cpr   <= 1'b0;
            r_en_spr   <= 1'b0;
            r_pix_cpr  <= '0;
            r_pix_spr  <= '0;
            r_beat_row <= '0;
            r_beat_col <= '0;
        end else begin
            r_en_cpr <= w_cur_rd_en;
            r_en_spr <= w_srch_rd_en;
            if (w_cur_rd_en) begin
                r_pix_cpr <= i_cur_data;
            end
            if (w_srch_rd_en) begin
                r_pix_spr  <= i_srch_data;
                r_beat_row <= r_srch_row;
                r_beat_col <= r_srch_col;
            end
        end
    end

    // A beat carrying strip row >= MACRO_DIM-1 closes the candidate whose top row is
    // MACRO_DIM-1 rows above it.
    assign w_beat_v = r_en_spr && (r_beat_row >= SW'(MACRO_DIM - 1));
    assign w_beat_x = r_beat_col;
    assign w_beat_y = NW'(r_beat_row - SW'(MACRO_DIM - 1));

    if (PIPE_LAT == 0) begin : g_no_lat
        assign w_out_v = w_beat_v;
        assign w_out_x = w_beat_x;
        assign w_out_y = w_beat_y;
    end else begin : g_lat
        logic [PIPE_LAT-1:0] r_pv;
        logic [NW-1:0]       r_px [PIPE_LAT];
        logic [NW-1:0]       r_py [PIPE_LAT];

        // Delay candidate tags to line up with the SAD at the comparator
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_pv <= '0;
                for (int i = 0; i < int'(PIPE_LAT); i++) begin
                    r_px[i] <= '0;
                    r_py[i] <= '0;
                end
            end else begin
                r_pv[0] <= w_beat_v;
                r_px[0] <= w_beat_x;
                r_py[0] <= w_beat_y;
                for (int i = 1; i < int'(PIPE_LAT); i++) begin
                    r_pv[i] <= r_pv[i-1];
                    r_px[i] <= r_px[i-1];
                    r_py[i] <= r_py[i-1];
                end
            end
        end

        assign w_out_v = r_pv[PIPE_LAT-1];
        assign w_out_x = r_px[PIPE_LAT-1];
        assign w_out_y = r_py[PIPE_LAT-1];
    end

    // Remember the last qualified offset so cand_x/cand_y hold between pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cand_x <= '0;
            r_cand_y <= '0;
        end else if (w_out_v) begin
            r_cand_x <= w_out_x;
            r_cand_y <= w_out_y;
        end
    end

    assign o_busy          = (r_state != StIdle);
    assign o_done          = (r_state == StFin);
    assign o_cur_rd_en     = w_cur_rd_en;
    assign o_cur_row       = r_cur_row;
    assign o_srch_rd_en    = w_srch_rd_en;
    assign o_srch_row      = r_srch_row;
    assign o_srch_col      = SW'(r_srch_col);
    assign o_pixel_cpr_out = r_pix_cpr;
    assign o_pixel_spr_out = r_pix_spr;
    assign o_en_cpr        = r_en_cpr;
    assign o_en_spr        = r_en_spr;
    assign o_valid         = w_out_v;
    assign o_cand_x        = w_out_v ? w_out_x : r_cand_x;
    assign o_cand_y        = w_out_v ? w_out_y : r_cand_y;

endmodule
